// File: rtl/avalon_master_queue.sv
// In-order request queue that issues core loads/stores one at a time on an Avalon-MM bus,
// honouring waitrequest and returning read data (optionally byte-reversed) to the core.
`timescale 1ns/1ps
module avalon_master_queue #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter bit          BYTE_SWAP  = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  // Core request side
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_address,
  input  logic [DATA_WIDTH-1:0]     req_writedata,
  input  logic [DATA_WIDTH/8-1:0]   req_byteenable,
  // Core response side
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_readdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      idle,
  // Avalon-MM master
  output logic [ADDR_WIDTH-1:0]     address,
  output logic                      read,
  output logic                      write,
  output logic [DATA_WIDTH-1:0]     writedata,
  output logic [DATA_WIDTH/8-1:0]   byteenable,
  input  logic                      waitrequest,
  input  logic [DATA_WIDTH-1:0]     readdata
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;
  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = PtrW + 1;

  function automatic logic [DATA_WIDTH-1:0] f_swap(input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] s;
    s = d;
    if (BYTE_SWAP) begin
      for (int i = 0; i < BeWidth; i++) begin
        s[8*i +: 8] = d[8*(BeWidth-1-i) +: 8];
      end
    end
    return s;
  endfunction

  // Queue storage; contents are don't-care while unoccupied, so no reset is needed
  logic                    r_mem_write [DEPTH];
  logic [ADDR_WIDTH-1:0]   r_mem_addr  [DEPTH];
  logic [DATA_WIDTH-1:0]   r_mem_wdata [DEPTH];
  logic [BeWidth-1:0]      r_mem_be    [DEPTH];

  logic [PtrW-1:0]         r_wptr;
  logic [PtrW-1:0]         r_rptr;
  logic [CntW-1:0]         r_count;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_readdata;

  logic                    w_enq;
  logic                    w_deq;
  logic                    w_nonempty;
  logic                    w_head_write;
  logic                    w_stall;

  assign w_nonempty   = (r_count != '0);
  assign req_ready    = (r_count != CntW'(DEPTH));
  assign w_enq        = req_valid && req_ready;
  assign w_head_write = r_mem_write[r_rptr];
  assign w_deq        = (read || write) && !waitrequest;
  assign w_stall      = (read || write) && waitrequest;

  assign count        = r_count;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_readdata = r_rsp_readdata;
  assign idle         = !w_nonempty && !r_rsp_valid;

  // Head entry drives the bus; everything is zeroed while the queue is empty
  always_comb begin
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    byteenable = '0;
    if (w_nonempty) begin
      read       = !w_head_write;
      write      = w_head_write;
      address    = r_mem_addr[r_rptr];
      writedata  = f_swap(r_mem_wdata[r_rptr]);
      byteenable = r_mem_be[r_rptr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_write[r_wptr] <= req_write;
      r_mem_addr[r_wptr]  <= req_address;
      r_mem_wdata[r_wptr] <= req_writedata;
      r_mem_be[r_wptr]    <= req_byteenable;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_readdata <= '0;
    end else begin
      if (w_enq) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_deq) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rsp_valid <= w_deq && !w_head_write;
      if (w_deq && !w_head_write) begin
        r_rsp_readdata <= f_swap(readdata);
      end
    end
  end

  // Avalon rule: a stalled master must not change anything it is driving
  a_stall_stable: assert property (@(posedge clk)
    (!reset && w_stall) |=> $stable({read, write, address, writedata, byteenable}));

endmodule
